// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one line-wide memory port between I-cache and D-cache
// Grant is locked until mem_ready; a one-cycle GAP forces a command deassertion between transactions.
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              proc_reset,
   input  logic              i_mem_read,
   input  logic [ADDR_W-1:0] i_mem_addr,
   output logic [LINE_W-1:0] i_mem_rdata,
   output logic              i_mem_ready,
   input  logic              d_mem_read,
   input  logic              d_mem_write,
   input  logic [ADDR_W-1:0] d_mem_addr,
   input  logic [LINE_W-1:0] d_mem_wdata,
   output logic [LINE_W-1:0] d_mem_rdata,
   output logic              d_mem_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, GAP} state_t;
   typedef enum logic {CLI_I, CLI_D} client_t;

   state_t            state;
   client_t           last_grant;
   logic [LINE_W-1:0] rdata_q;
   logic              req_i;
   logic              req_d;

   assign req_i = i_mem_read;
   assign req_d = d_mem_read | d_mem_write;

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state      <= IDLE;
         last_grant <= CLI_I;
         rdata_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_i && req_d)
                  state <= (last_grant == CLI_I) ? SERVE_D : SERVE_I;
               else if (req_d)
                  state <= SERVE_D;
               else if (req_i)
                  state <= SERVE_I;
            end
            SERVE_I: begin
               if (mem_ready) begin
                  rdata_q    <= mem_rdata;
                  last_grant <= CLI_I;
                  state      <= GAP;
               end else if (!req_i) begin
                  state <= IDLE;
               end
            end
            SERVE_D: begin
               if (mem_ready) begin
                  rdata_q    <= mem_rdata;
                  last_grant <= CLI_D;
                  state      <= GAP;
               end else if (!req_d) begin
                  state <= IDLE;
               end
            end
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Live pass-through so a cache changing its address mid-grant is followed.
   always_comb begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      i_mem_ready = 1'b0;
      d_mem_ready = 1'b0;
      case (state)
         SERVE_I: begin
            mem_read    = i_mem_read;
            mem_addr    = i_mem_addr;
            i_mem_ready = mem_ready;
         end
         SERVE_D: begin
            mem_write   = d_mem_write;
            mem_read    = d_mem_read & ~d_mem_write;
            mem_addr    = d_mem_addr;
            mem_wdata   = d_mem_wdata;
            d_mem_ready = mem_ready;
         end
         default: ;
      endcase
   end

   assign i_mem_rdata = mem_ready ? mem_rdata : rdata_q;
   assign d_mem_rdata = mem_ready ? mem_rdata : rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-client arbiter that lets the instruction cache and the data cache (both direct-mapped, 128-bit line, 28-bit line address) share one main-memory port.
- Sits directly downstream of both caches' memory interfaces and upstream of the memory model/controller.
- Grants are round-robin, locked until memory signals completion.
- Read data is held after completion so a cache can consume the line the cycle after ready.

Parameters:
- ADDR_W, 28, line-address width (word address bits [29:2]).
- LINE_W, 128, cache line width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- proc_reset  input  1  synchronous, active-high reset.
- i_mem_read  input  1  I-cache read request; held high until its ready.
- i_mem_addr  input  ADDR_W  I-cache line address.
- i_mem_rdata  output  LINE_W  line data to I-cache.
- i_mem_ready  output  1  one-cycle completion pulse to I-cache.
- d_mem_read  input  1  D-cache read request; held until ready.
- d_mem_write  input  1  D-cache write-back request; held until ready.
- d_mem_addr  input  ADDR_W  D-cache line address.
- d_mem_wdata  input  LINE_W  D-cache write-back data.
- d_mem_rdata  output  LINE_W  line data to D-cache.
- d_mem_ready  output  1  one-cycle completion pulse to D-cache.
- mem_read  output  1  read command to memory.
- mem_write  output  1  write command to memory.
- mem_addr  output  ADDR_W  address to memory.
- mem_wdata  output  LINE_W  write data to memory.
- mem_rdata  input  LINE_W  memory read data; valid when mem_ready=1.
- mem_ready  input  1  memory completion pulse for the current command.

Behaviour:
- Clock and reset: one clock, clk. proc_reset is synchronous and active-high.
- State register values: IDLE, SERVE_I, SERVE_D, GAP.
- Reset (sampled at a clk edge, including mid-transaction):
  - state<=IDLE, last_grant<=I (so D wins the first tie), rdata_q<=0.
  - Outputs combinationally 0 while in IDLE. Any in-flight memory command is abandoned.
- Requests: req_i=i_mem_read; req_d=d_mem_read|d_mem_write.
- IDLE:
  - All memory outputs 0; both readies 0.
  - Only req_i: next state SERVE_I. Only req_d: next state SERVE_D.
  - Both: grant the client that was not last_grant.
  - Neither: stay in IDLE.
  - Grant latency is one cycle: request at edge n, memory sees the command after edge n+1.
- SERVE_I:
  - mem_read=i_mem_read, mem_write=0, mem_addr=i_mem_addr, mem_wdata=0 (combinational pass-through).
  - i_mem_ready=mem_ready.
- SERVE_D:
  - mem_write=d_mem_write; mem_read=d_mem_read&~d_mem_write (write wins if both are high).
  - mem_addr=d_mem_addr, mem_wdata=d_mem_wdata.
  - d_mem_ready=mem_ready.
- Pass-through is live every cycle, so a cache that updates its address register after entering its allocate/write-back state is tracked.
- Completion, in either SERVE state with mem_ready=1:
  - Granted ready pulses in that same cycle.
  - rdata_q<=mem_rdata; last_grant<=granted client; next state GAP.
- Request dropped in a SERVE state with mem_ready=0: protocol error. Next state IDLE, no ready pulse, last_grant unchanged.
- Ungranted client: ready always 0; request simply waits.
- GAP:
  - Exactly one cycle with all memory outputs 0, then IDLE.
  - Guarantees memory sees a deassertion between back-to-back commands, e.g. D write-back followed immediately by D allocate read.
- Read data: i_mem_rdata = d_mem_rdata = mem_ready ? mem_rdata : rdata_q.
  - Both clients see the data; only the readied client may consume it.
  - rdata_q holds until the next completion, so data remains valid in the cycle after ready.
- No ready pulse is ever forwarded outside SERVE_I/SERVE_D. A spurious mem_ready in IDLE/GAP is ignored and does not load rdata_q.
- Fairness: with both clients requesting continuously, grants alternate D,I,D,I… Worst-case wait for one client = one other transaction + GAP + IDLE cycles.

Test Plan:
- Reset then lone I read: i_mem_read=1, addr=28'h0000010; memory ready 3 cycles after mem_read rises with rdata=128'hA5…A5 -> mem_read high from the 2nd cycle, mem_addr=28'h0000010, i_mem_ready 1 cycle, i_mem_rdata=A5…A5 that cycle and the next, d_mem_ready stays 0.
- D write-back then allocate: d_mem_write=1, addr=28'h1234567, wdata=128'hDEAD…BEEF; after ready, cache switches to d_mem_read addr=28'h0ABCDEF -> mem_write pulse train ends, exactly one GAP cycle with mem_read=mem_write=0, then read to 28'h0ABCDEF.
- Simultaneous requests after reset, both held -> D granted first, then I, then D; mem_addr alternates per completion.
- Both d_mem_read and d_mem_write high -> mem_write=1, mem_read=0.
- proc_reset asserted for 1 cycle while SERVE_D awaiting ready -> next cycle mem_read=mem_write=0, state IDLE, rdata outputs 0; a late mem_ready produces no client ready.
- mem_ready pulse while IDLE with mem_rdata=128'h1 -> no ready to either cache, rdata_q unchanged.
